// File: rtl/vec_mem_responder.sv
// vec_mem_responder: serialises scalar/vector load-store requests into byte beats on an 8-bit sync RAM
//   clk, reset (sync, active-high)
//   req_valid/req_ready/req_write/req_vector/req_addr/req_wdata : request handshake
//   resp_valid/resp_ready/resp_rdata                             : response handshake
//   busy                                                         : high whenever not IDLE
//   ram_addr/ram_wdata/ram_wren/ram_q                            : single-port RAM, 1-cycle read latency
//   optional VEC_WRAP_CHECK_EN adds resp_error and rejects vector accesses that wrap
module vec_mem_responder #(
  parameter int ADDR_W = 16,
  parameter int LANES  = 16,
  parameter int LANE_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic                      req_vector,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [LANES*LANE_W-1:0]   req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [LANES*LANE_W-1:0]   resp_rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [LANE_W-1:0]         ram_wdata,
  output logic                      ram_wren,
  input  logic [LANE_W-1:0]         ram_q
`ifdef VEC_WRAP_CHECK_EN
  ,
  output logic                      resp_error
`endif
);
  localparam int BW = $clog2(LANES);
  typedef enum logic [2:0] {IDLE, WR_BURST, RD_BURST, RD_DRAIN, DONE} state_t;
  state_t                    r_state, w_next;
  logic [BW-1:0]             r_beat, w_last, w_cap;
  logic [ADDR_W-1:0]         r_base;
  logic                      r_write, r_vector, r_err;
  logic [LANES*LANE_W-1:0]   r_wbuf, r_rbuf;
  logic                      w_accept, w_wrap_err;
  assign w_accept = req_valid && req_ready;
  assign w_last   = r_vector ? BW'(LANES - 1) : '0;
  // read data arrives one beat late, so beat b captures lane b-1 and the drain cycle the last lane
  assign w_cap    = (r_state == RD_DRAIN) ? w_last : r_beat - BW'(1);
`ifdef VEC_WRAP_CHECK_EN
  logic [ADDR_W:0] w_end;
  assign w_end      = {1'b0, req_addr} + (ADDR_W+1)'(LANES - 1);
  assign w_wrap_err = req_vector && w_end[ADDR_W];
  assign resp_error = resp_valid && r_err;
`else
  assign w_wrap_err = 1'b0;
`endif
  assign ram_addr   = r_base + ADDR_W'(r_beat);
  assign ram_wdata  = ram_wren ? r_wbuf[r_beat*LANE_W +: LANE_W] : '0;
  assign resp_rdata = (resp_valid && !r_write && !r_err) ? r_rbuf : '0;
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    ram_wren   = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) w_next = w_wrap_err ? DONE : req_write ? WR_BURST : RD_BURST;
      end
      WR_BURST: begin
        ram_wren = 1'b1;
        if (r_beat == w_last) w_next = DONE;
      end
      RD_BURST: if (r_beat == w_last) w_next = RD_DRAIN;
      RD_DRAIN: w_next = DONE;
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat   <= '0;
      r_base   <= '0;
      r_write  <= 1'b0;
      r_vector <= 1'b0;
      r_err    <= 1'b0;
      r_wbuf   <= '0;
      r_rbuf   <= '0;
    end else begin
      if (w_accept) begin
        r_beat   <= '0;
        r_base   <= req_addr;
        r_write  <= req_write;
        r_vector <= req_vector;
        r_err    <= w_wrap_err;
        r_wbuf   <= req_wdata;
        r_rbuf   <= '0;
      end
      if ((r_state == WR_BURST || r_state == RD_BURST) && r_beat != w_last) r_beat <= r_beat + BW'(1);
      if ((r_state == RD_BURST && r_beat != '0) || r_state == RD_DRAIN) r_rbuf[w_cap*LANE_W +: LANE_W] <= ram_q;
    end
  end
endmodule

// File: tb/tb_vec_mem_responder.sv
// tb_vec_mem_responder: scoreboard bench with a behavioural RAM and a shadow reference memory
module tb_vec_mem_responder;
  localparam int W = 128;
  logic          clk, reset, req_valid, req_ready, req_write, req_vector;
  logic [15:0]   req_addr, ram_addr;
  logic [W-1:0]  req_wdata, resp_rdata;
  logic          resp_valid, resp_ready, busy, ram_wren;
  logic [7:0]    ram_wdata, ram_q;
  logic [7:0]    mem [0:65535];
  logic [7:0]    ref_mem [0:65535];
  logic [W-1:0]  rq [$];
  logic [23:0]   wq [$];
  logic [23:0]   we;
  int            total = 0, bad = 0, cyc = 0;
  vec_mem_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_vector(req_vector), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ram_wren === 1'b1) begin
      if (wq.size() == 0) chk("wr_extra", ram_wren, 0);
      else begin
        we = wq.pop_front();
        chk("wr_addr", ram_addr, we[23:8]);
        chk("wr_data", ram_wdata, we[7:0]);
      end
    end
  end
  task automatic do_req(input bit w, input bit v, input logic [15:0] a, input logic [W-1:0] wd, input int hold);
    int n, lat, c0;
    logic [15:0]  ad;
    logic [W-1:0] e, snap;
    n   = v ? 16 : 1;
    lat = w ? (v ? 17 : 2) : (v ? 18 : 3);
    e   = '0;
    for (int i = 0; i < n; i++) begin
      ad = a + 16'(i);
      if (w) begin
        ref_mem[ad] = wd[8*i +: 8];
        wq.push_back({ad, wd[8*i +: 8]});
      end else e[8*i +: 8] = ref_mem[ad];
    end
    rq.push_back(e);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_write = w; req_vector = v; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    c0 = cyc;
    req_valid = 0; req_wdata = {4{$urandom}}; req_addr = 16'($urandom);
    chk("busy_run", busy, 1);
    chk("req_ready_run", req_ready, 0);
    for (int k = 0; k < 40; k++) begin
      if (resp_valid === 1'b1) break;
      @(negedge clk);
    end
    chk("resp_seen", resp_valid, 1);
    if (resp_valid === 1'b1) begin
      chk("latency", cyc - c0 + 1, lat);
      chk("rdata", resp_rdata, rq.pop_front());
    end
    snap = resp_rdata;
    for (int k = 0; k < hold; k++) begin
      req_valid = (k == 2); req_write = 1; req_vector = 0;
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, snap);
      chk("hold_busy", busy, 1);
      chk("hold_req_ready", req_ready, 0);
    end
    req_valid = 0;
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk("valid_drop", resp_valid, 0);
    chk("ready_back", req_ready, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [W-1:0] wd;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i) ^ 8'(i >> 8) ^ 8'h5a;
      ref_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5a;
    end
    reset = 1; req_valid = 0; req_write = 0; req_vector = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    reset = 0;
    do_req(1, 0, 16'h0010, 128'hA5, 0);
    for (int i = 0; i < 16; i++) wd[8*i +: 8] = 8'(i);
    do_req(1, 1, 16'h0100, wd, 0);
    do_req(0, 1, 16'h0100, 0, 0);
    do_req(0, 0, 16'h0105, 0, 5);
    do_req(0, 1, 16'hFFF8, 0, 0);
    do_req(1, 1, 16'hFFFC, {4{$urandom}}, 0);
    do_req(0, 1, 16'hFFFC, 0, 1);
    do_req(0, 0, 16'h0010, 0, 0);
    wd = {4{$urandom}};
    for (int i = 0; i < 8; i++) begin
      ref_mem[16'h0200 + 16'(i)] = wd[8*i +: 8];
      wq.push_back({16'h0200 + 16'(i), wd[8*i +: 8]});
    end
    @(negedge clk);
    req_valid = 1; req_write = 1; req_vector = 1; req_addr = 16'h0200; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    repeat (7) @(negedge clk);
    chk("beat7_wren", ram_wren, 1);
    chk("beat7_addr", ram_addr, 16'h0207);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("midrst_wren", ram_wren, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_no_resp", resp_valid, 0);
    end
    do_req(0, 0, 16'h0203, 0, 0);
    do_req(0, 1, 16'h0200, 0, 0);
    for (int t = 0; t < 8; t++)
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), {4{$urandom}}, $urandom_range(0, 2));
    chk("wq_empty", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vec_mem_responder.md
Name: vec_mem_responder

Overview:
- Memory-side responder for the CPU's memory stage.
- Accepts scalar (8-bit) and vector (128-bit, 16 lanes) load/store requests over a valid/ready handshake.
- Serialises each request into byte beats on a single-port synchronous 8-bit data RAM, then returns the read data or a write acknowledge over a valid/ready response.
- Drives a busy flag that the hazard unit uses to stall the pipeline.

Parameters:
ADDR_W, 16, byte address width; wraps modulo 2^ADDR_W
LANES, 16, bytes per vector access
LANE_W, 8, RAM data width and lane width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_vector  input  1  1 = vector access of LANES bytes, 0 = scalar single byte
req_addr  input  ADDR_W  base byte address
req_wdata  input  LANES*LANE_W  store data; lane i = bits [8i+7:8i]; scalar uses lane 0
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  LANES*LANE_W  load data; scalar result in lane 0, upper lanes zero; zero for stores
busy  output  1  high whenever state != IDLE
ram_addr  output  ADDR_W  RAM address
ram_wdata  output  LANE_W  RAM write byte
ram_wren  output  1  RAM write enable
ram_q  input  LANE_W  RAM read data; one-cycle latency after ram_addr

Behaviour:
- Reset values: state=IDLE, beat=0, req_ready=1, resp_valid=0, resp_rdata=0, busy=0, ram_wren=0, ram_addr=0, ram_wdata=0. Internal buffers are cleared.
- Reset is honoured in any state, including mid-burst: ram_wren is low from the next cycle and any in-flight request is discarded with no response.
- Beat count N = LANES if req_vector, else 1.
- A request is accepted when req_valid & req_ready at a rising edge. The responder latches addr, write, vector and wdata; beat = 0.
- IDLE: on accept go to WR_BURST if req_write, else RD_BURST.
- WR_BURST, one beat per cycle:
  - ram_addr = base + beat (mod 2^ADDR_W), ram_wdata = wbuf lane[beat], ram_wren = 1.
  - On beat = N-1, go to DONE; otherwise beat++.
- RD_BURST, one beat per cycle:
  - ram_addr = base + beat, ram_wren = 0.
  - When beat > 0, capture ram_q into rbuf lane[beat-1].
  - On beat = N-1, go to RD_DRAIN.
- RD_DRAIN: capture ram_q into rbuf lane[N-1]; ram_wren = 0; go to DONE.
- DONE:
  - resp_valid = 1; resp_rdata = rbuf (reads) or 0 (writes).
  - Hold until resp_ready. resp_rdata stays stable while resp_valid & !resp_ready.
  - On resp_valid & resp_ready go to IDLE; resp_valid drops the next cycle.
- RAM outputs are combinational from registered state, beat and base. ram_wren is 0 in IDLE, RD_*, and DONE.
- Latency (accept edge -> resp_valid):
  - scalar store 2 cycles; vector store 17.
  - scalar load 3 cycles; vector load 18.
- No new request is accepted until the response handshake completes (req_ready = 0 in DONE, even when resp_ready = 1). Minimum back-to-back spacing is one IDLE cycle.
- Address wrap: base 0xFFF8 with a vector access touches 0xFFF8..0xFFFF, then 0x0000..0x0007.
- req_* inputs are ignored outside IDLE. req_valid may drop at any time without effect.

Optional Feature:
VEC_WRAP_CHECK_EN
- Enabled:
  - Adds output port resp_error (1 bit, reset 0).
  - If a vector request has base + LANES - 1 > 2^ADDR_W - 1, the responder accepts it, performs no RAM access (ram_wren stays 0), and goes directly IDLE -> DONE.
  - It then presents resp_valid = 1, resp_error = 1, resp_rdata = 0.
  - resp_error = 0 for all other responses.
- Disabled: no resp_error port; addresses wrap as described in Behaviour.

Test Plan:
- Scalar store, addr 0x0010, wdata lane0 = 0xA5 -> exactly one cycle with ram_wren = 1, ram_addr = 0x0010, ram_wdata = 0xA5; resp_valid 2 cycles after accept, resp_rdata = 0.
- Vector store at 0x0100 with lanes 0x00..0x0F, then vector load at 0x0100 -> 16 consecutive writes to 0x0100..0x010F; load resp_rdata = 0x0F0E...0100, resp_valid 18 cycles after accept.
- Scalar load from 0x0105 after the above -> resp_rdata = 0x...0005 with upper 120 bits zero; latency 3.
- Hold resp_ready = 0 for 5 cycles in DONE -> resp_valid and resp_rdata stable, busy = 1, req_ready = 0; a req_valid pulse meanwhile is ignored.
- Vector load at 0xFFF8 -> ram_addr sequence 0xFFF8..0xFFFF, 0x0000..0x0007. With VEC_WRAP_CHECK_EN: no RAM access, resp_error = 1 on the next cycle.
- Assert reset at beat 7 of a vector store -> ram_wren = 0 the next cycle, resp_valid never asserts, req_ready = 1; a following scalar load completes normally.
